ibex_obi_responder: RTL and testbench
=====================================

Name: ibex_obi_responder

Overview:
- Protocol-compliant memory responder for one Ibex OBI-style port (instruction or data) in the formal harness. One instance per port in the wrapper.
- Takes solver-driven random values and turns them into legal gnt/rvalid/rdata/err sequences.
- Tracks outstanding transactions in order and optionally bounds stalls for liveness checks.
- Flags core-side protocol violations.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered requests; legal range 1..4.
- FAIRNESS, 0, when 1, enforces the stall bounds below; when 0, there are no forced events.
- MAX_GNT_STALL, 3, maximum consecutive cycles req is held without gnt before gnt is forced.
- MAX_RVALID_STALL, 3, maximum consecutive cycles with an outstanding request but no rvalid before rvalid is forced.
- ALLOW_ERR, 1, when 0, err_o is tied to 0.

Ports:
- clock input 1 system clock, rising edge.
- reset input 1 asynchronous active-high reset.
- req_i input 1 core request.
- addr_i input 32 request address.
- we_i input 1 write enable.
- be_i input 4 byte enables.
- wdata_i input 32 write data.
- gnt_o output 1 grant, combinational.
- rvalid_o output 1 response valid, combinational from state.
- rdata_o output 32 response data.
- err_o output 1 response error.
- rand_gnt_i input 1 solver-free grant choice.
- rand_rvalid_i input 1 solver-free response choice.
- rand_rdata_i input 32 solver-free read data.
- rand_err_i input 1 solver-free error choice.
- outstanding_o output 3 current outstanding count.
- resp_addr_o output 32 address of the transaction answered by the current rvalid.
- resp_we_o output 1 we of the transaction answered by the current rvalid.
- protocol_err_o output 1 sticky core protocol violation flag.

Behaviour:
- Reset (async assert, sync deassert by the harness): the following are all 0.
  - Internal state: count, FIFO pointers, gnt_stall, rv_stall, pending-request capture, protocol_err_o.
  - Outputs while reset is high: gnt_o, rvalid_o, rdata_o, err_o, resp_addr_o, resp_we_o.
- gnt_o = req_i & (count < MAX_OUTSTANDING) & (rand_gnt_i | (FAIRNESS & gnt_stall == MAX_GNT_STALL)).
- A full FIFO blocks gnt even when forced. The forced grant takes effect once count drops.
- rvalid_o = (count != 0) & (rand_rvalid_i | (FAIRNESS & rv_stall == MAX_RVALID_STALL)).
  - Because count updates on the clock edge, rvalid is never in the same cycle as its own gnt. Minimum latency gnt→rvalid is 1 cycle.
- Responses are returned strictly in grant order.
- When rvalid_o = 1:
  - rdata_o = head.we ? 0 : rand_rdata_i.
  - err_o = ALLOW_ERR & rand_err_i.
  - resp_addr_o and resp_we_o come from the FIFO head.
  - Otherwise rdata_o, err_o, resp_addr_o and resp_we_o are 0.
- FIFO:
  - Depth MAX_OUTSTANDING, entries {addr, we}, circular pointers wrap at depth.
  - Push on gnt_o, pop on rvalid_o.
  - count_next = count + gnt_o − rvalid_o; simultaneous push and pop leaves count unchanged.
  - Push to full and pop from empty are impossible by construction.
- gnt_stall:
  - Increments when req_i & !gnt_o, saturating at MAX_GNT_STALL.
  - Clears on gnt_o or !req_i.
- rv_stall:
  - Increments when count != 0 & !rvalid_o, saturating at MAX_RVALID_STALL.
  - Clears on rvalid_o or count == 0.
- Protocol checker:
  - When req_i & !gnt_o, capture {addr, we, be, wdata} and set waiting = 1.
  - On the next cycle while waiting, protocol_err_o sets if req_i == 0 or any captured field differs.
  - For reads, wdata is ignored.
  - waiting clears on gnt_o.
  - protocol_err_o stays set until reset.
- Reset mid-transaction: all outstanding entries are discarded, and no rvalid is issued for them after reset.

Test Plan:
- Reset high for 2 cycles with req_i=1, rand_gnt_i=1, rand_rvalid_i=1 -> gnt_o=0, rvalid_o=0, outstanding_o=0 throughout.
- req_i=1, addr 0x100, rand_gnt_i=1 in cycle 0; rand_rvalid_i=1, rand_rdata_i=0xDEADBEEF in cycle 1 -> gnt_o=1 in cycle 0; in cycle 1 rvalid_o=1, rdata_o=0xDEADBEEF, resp_addr_o=0x100; outstanding_o 1 then 0.
- Two grants to 0x10 then 0x14 with rand_rvalid_i=0; then req_i=1 -> gnt_o=0 at outstanding_o=2; then two rvalids -> resp_addr_o 0x10 then 0x14 in order.
- FAIRNESS=1, MAX_GNT_STALL=3, req_i=1 held, rand_gnt_i=0 -> gnt_o=1 on the 4th cycle of req. Same stall test for rvalid: rvalid_o=1 on the 4th cycle with count=1.
- Same-cycle gnt and rvalid with count=1 -> count stays 1, FIFO head advances, and the new entry is answered next.
- req_i=1 addr 0x20 with no gnt; next cycle addr 0x24 -> protocol_err_o=1 from that cycle and sticky until reset.

Source files
------------

// File: rtl/ibex_obi_responder.sv
// ibex_obi_responder
//
// Memory responder for one Ibex OBI-style port (instruction or data) used in
// the formal harness. Solver-driven random inputs are shaped into a legal
// gnt/rvalid/rdata/err sequence. Granted requests are tracked in order, and
// core-side protocol violations are flagged.
//
// Handshake: a request transfers on a cycle where req_i && gnt_o. Once req_i
// is raised without gnt_o, the core must keep req_i high and keep addr/we/be
// (and wdata for writes) stable until the grant. A response transfers on any
// cycle with rvalid_o. The core cannot back-pressure it. Responses come back
// strictly in grant order.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req_i/addr_i/we_i/be_i/wdata_i   core request channel
//   gnt_o               grant (combinational)
//   rvalid_o/rdata_o/err_o           response channel (combinational from state)
//   rand_*_i            free choices supplied by the solver
//   outstanding_o       number of granted but unanswered requests
//   resp_addr_o/resp_we_o            identity of the transaction being answered
//   protocol_err_o      sticky flag for core protocol violations
module ibex_obi_responder #(
    parameter int MAX_OUTSTANDING  = 2,
    parameter int FAIRNESS         = 0,
    parameter int MAX_GNT_STALL    = 3,
    parameter int MAX_RVALID_STALL = 3,
    parameter int ALLOW_ERR        = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        rand_gnt_i,
    input  logic        rand_rvalid_i,
    input  logic [31:0] rand_rdata_i,
    input  logic        rand_err_i,
    output logic [2:0]  outstanding_o,
    output logic [31:0] resp_addr_o,
    output logic        resp_we_o,
    output logic        protocol_err_o
);

    localparam int PTR_W   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int STALL_W = 8;

    logic [31:0]        fifo_addr [MAX_OUTSTANDING];
    logic               fifo_we   [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [2:0]         count;
    logic [STALL_W-1:0] gnt_stall;
    logic [STALL_W-1:0] rv_stall;
    logic               gnt_forced;
    logic               rv_forced;

    logic               waiting;
    logic [31:0]        cap_addr;
    logic               cap_we;
    logic [3:0]         cap_be;
    logic [31:0]        cap_wdata;
    logic               violation;
    logic               prot_err_q;

    // Pointers wrap at the FIFO depth, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign gnt_forced = (FAIRNESS != 0) && (gnt_stall == STALL_W'(MAX_GNT_STALL));
    assign rv_forced  = (FAIRNESS != 0) && (rv_stall == STALL_W'(MAX_RVALID_STALL));

    // A full FIFO blocks even a forced grant. The force stays armed until
    // count drops. The reset term keeps gnt low while reset is held.
    assign gnt_o = !reset && req_i && (count < 3'(MAX_OUTSTANDING)) &&
                   (rand_gnt_i || gnt_forced);

    // count only moves on the clock edge, so a request is never answered in
    // the cycle it is granted.
    assign rvalid_o = !reset && (count != 3'd0) && (rand_rvalid_i || rv_forced);

    assign outstanding_o = count;

    always_comb begin
        rdata_o     = '0;
        err_o       = 1'b0;
        resp_addr_o = '0;
        resp_we_o   = 1'b0;
        if (rvalid_o) begin
            resp_addr_o = fifo_addr[rd_ptr];
            resp_we_o   = fifo_we[rd_ptr];
            rdata_o     = fifo_we[rd_ptr] ? 32'h0 : rand_rdata_i;
            err_o       = (ALLOW_ERR != 0) && rand_err_i;
        end
    end

    // Entry storage needs no reset. Entries are only read while count != 0.
    always_ff @(posedge clock) begin
        if (gnt_o) begin
            fifo_addr[wr_ptr] <= addr_i;
            fifo_we[wr_ptr]   <= we_i;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            gnt_stall <= '0;
            rv_stall  <= '0;
        end else begin
            if (gnt_o) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rvalid_o) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({gnt_o, rvalid_o})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (gnt_o || !req_i) begin
                gnt_stall <= '0;
            end else if (gnt_stall < STALL_W'(MAX_GNT_STALL)) begin
                gnt_stall <= gnt_stall + 1'b1;
            end

            if (rvalid_o || (count == 3'd0)) begin
                rv_stall <= '0;
            end else if (rv_stall < STALL_W'(MAX_RVALID_STALL)) begin
                rv_stall <= rv_stall + 1'b1;
            end
        end
    end

    // A stalled request must stay asserted and unchanged. Write data is only
    // checked for writes.
    assign violation = waiting &&
                       (!req_i || (addr_i != cap_addr) || (we_i != cap_we) ||
                        (be_i != cap_be) || (cap_we && (wdata_i != cap_wdata)));

    // The flag is raised in the offending cycle and then held until reset.
    assign protocol_err_o = prot_err_q || violation;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            waiting    <= 1'b0;
            cap_addr   <= '0;
            cap_we     <= 1'b0;
            cap_be     <= '0;
            cap_wdata  <= '0;
            prot_err_q <= 1'b0;
        end else begin
            // waiting tracks "request pending without grant". It clears on a
            // grant or when req drops. A dropped req is itself a violation.
            waiting <= req_i && !gnt_o;
            if (req_i && !gnt_o) begin
                cap_addr  <= addr_i;
                cap_we    <= we_i;
                cap_be    <= be_i;
                cap_wdata <= wdata_i;
            end
            if (violation) begin
                prot_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_obi_responder.sv
module tb_ibex_obi_responder;

  logic        clock;
  logic        reset;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        rand_gnt_i;
  logic        rand_rvalid_i;
  logic [31:0] rand_rdata_i;
  logic        rand_err_i;
  logic [2:0]  outstanding_o;
  logic [31:0] resp_addr_o;
  logic        resp_we_o;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  // Expected responses, {we, addr}, in grant order.
  logic [32:0] exp_q[$];
  logic [32:0] exp_e;

  ibex_obi_responder #(
    .MAX_OUTSTANDING (2),
    .FAIRNESS        (1),
    .MAX_GNT_STALL   (3),
    .MAX_RVALID_STALL(3),
    .ALLOW_ERR       (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_i         (req_i),
    .addr_i        (addr_i),
    .we_i          (we_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .gnt_o         (gnt_o),
    .rvalid_o      (rvalid_o),
    .rdata_o       (rdata_o),
    .err_o         (err_o),
    .rand_gnt_i    (rand_gnt_i),
    .rand_rvalid_i (rand_rvalid_i),
    .rand_rdata_i  (rand_rdata_i),
    .rand_err_i    (rand_err_i),
    .outstanding_o (outstanding_o),
    .resp_addr_o   (resp_addr_o),
    .resp_we_o     (resp_we_o),
    .protocol_err_o(protocol_err_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs;
    req_i = 1'b0; addr_i = '0; we_i = 1'b0; be_i = 4'hf; wdata_i = '0;
    rand_gnt_i = 1'b0; rand_rvalid_i = 1'b0; rand_rdata_i = '0; rand_err_i = 1'b0;
  endtask

  task automatic reset_pulse;
    reset = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    req_i = 1'b1; addr_i = 32'h200; rand_gnt_i = 1'b1; rand_rvalid_i = 1'b1;
    rand_rdata_i = 32'hffff_ffff; rand_err_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt_o); end
      checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid_o); end
      checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", outstanding_o); end
      checks++; if ({rdata_o, err_o, resp_addr_o, resp_we_o, protocol_err_o} !== '0) begin
        errors++; $display("FAIL reset_resp: rdata %h err %b addr %h we %b perr %b want all 0",
                           rdata_o, err_o, resp_addr_o, resp_we_o, protocol_err_o);
      end
      tick();
    end
    idle_inputs();
    reset = 1'b0;
    #1;
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL post_reset_count: got %0d want 0", outstanding_o); end
    tick();
  endtask

  task automatic test_single_read;
    idle_inputs();
    req_i = 1'b1; addr_i = 32'h100; rand_gnt_i = 1'b1; rand_rvalid_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b want 1", gnt_o); end
    checks++; if (rvalid_o !== 1'b0) begin errors++; $display("FAIL single_same_cycle_rvalid: got %b want 0", rvalid_o); end
    exp_q.push_back({1'b0, 32'h100});
    tick();
    idle_inputs();
    rand_rvalid_i = 1'b1; rand_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", outstanding_o); end
    checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b want 1", rvalid_o); end
    exp_e = exp_q.pop_front();
    checks++; if (resp_addr_o !== exp_e[31:0]) begin errors++; $display("FAIL single_addr: got %h want %h", resp_addr_o, exp_e[31:0]); end
    checks++; if (rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_rdata: got %h want deadbeef", rdata_o); end
    tick();
    idle_inputs();
    #1;
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_in_order_full;
    idle_inputs();
    req_i = 1'b1; addr_i = 32'h10; rand_gnt_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL order_gnt0: got %b want 1", gnt_o); end
    exp_q.push_back({1'b0, 32'h10});
    tick();
    addr_i = 32'h14;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL order_gnt1: got %b want 1", gnt_o); end
    exp_q.push_back({1'b0, 32'h14});
    tick();
    addr_i = 32'h18;
    #1;
    checks++; if (outstanding_o !== 3'd2) begin errors++; $display("FAIL order_count2: got %0d want 2", outstanding_o); end
    checks++; if (gnt_o !== 1'b0) begin errors++; $display("FAIL order_full_gnt: got %b want 0", gnt_o); end
    tick();
    // Request 0x18 stays pending while the two responses drain.
    rand_gnt_i = 1'b0; rand_rvalid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (rvalid_o !== 1'b1) begin errors++; $display("FAIL order_rvalid%0d: got %b want 1", i, rvalid_o); end
      exp_e = exp_q.pop_front();
      checks++; if (resp_addr_o !== exp_e[31:0]) begin errors++; $display("FAIL order_addr%0d: got %h want %h", i, resp_addr_o, exp_e[31:0]); end
      tick();
    end
    rand_gnt_i = 1'b1; rand_rvalid_i = 1'b0;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL order_gnt2: got %b want 1", gnt_o); end
    exp_q.push_back({1'b0, 32'h18});
    tick();
    idle_inputs();
    rand_rvalid_i = 1'b1;
    #1;
    exp_e = exp_q.pop_front();
    checks++; if (resp_addr_o !== exp_e[31:0]) begin errors++; $display("FAIL order_addr2: got %h want %h", resp_addr_o, exp_e[31:0]); end
    tick();
  endtask

  task automatic test_fairness;
    logic exp_b;
    idle_inputs();
    req_i = 1'b1; addr_i = 32'h40;
    for (int i = 0; i < 4; i++) begin
      exp_b = (i == 3);
      #1;
      checks++; if (gnt_o !== exp_b) begin errors++; $display("FAIL fair_gnt_cyc%0d: got %b want %b", i, gnt_o, exp_b); end
      if (exp_b) exp_q.push_back({1'b0, 32'h40});
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      exp_b = (i == 3);
      #1;
      checks++; if (rvalid_o !== exp_b) begin errors++; $display("FAIL fair_rvalid_cyc%0d: got %b want %b", i, rvalid_o, exp_b); end
      if (exp_b) begin
        exp_e = exp_q.pop_front();
        checks++; if (resp_addr_o !== exp_e[31:0]) begin errors++; $display("FAIL fair_addr: got %h want %h", resp_addr_o, exp_e[31:0]); end
      end
      tick();
    end
    #1;
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL fair_count0: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_back_to_back;
    idle_inputs();
    req_i = 1'b1; addr_i = 32'h50; rand_gnt_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL b2b_gnt0: got %b want 1", gnt_o); end
    exp_q.push_back({1'b0, 32'h50});
    tick();
    addr_i = 32'h54; we_i = 1'b1; be_i = 4'h3; wdata_i = 32'hCAFE;
    rand_rvalid_i = 1'b1; rand_rdata_i = 32'h1234_5678; rand_err_i = 1'b0;
    #1;
    checks++; if ({gnt_o, rvalid_o} !== 2'b11) begin errors++; $display("FAIL b2b_both: got gnt %b rvalid %b want 1 1", gnt_o, rvalid_o); end
    exp_e = exp_q.pop_front();
    checks++; if ({resp_we_o, resp_addr_o} !== exp_e) begin errors++; $display("FAIL b2b_head0: got %b/%h want %b/%h", resp_we_o, resp_addr_o, exp_e[32], exp_e[31:0]); end
    checks++; if (rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL b2b_rdata0: got %h want 12345678", rdata_o); end
    exp_q.push_back({1'b1, 32'h54});
    tick();
    idle_inputs();
    rand_rvalid_i = 1'b1; rand_rdata_i = 32'hAAAA_5555; rand_err_i = 1'b1;
    #1;
    checks++; if (outstanding_o !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d want 1", outstanding_o); end
    exp_e = exp_q.pop_front();
    checks++; if ({resp_we_o, resp_addr_o} !== exp_e) begin errors++; $display("FAIL b2b_head1: got %b/%h want %b/%h", resp_we_o, resp_addr_o, exp_e[32], exp_e[31:0]); end
    checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL b2b_write_rdata: got %h want 0", rdata_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL b2b_err: got %b want 1", err_o); end
    tick();
    idle_inputs();
    #1;
    checks++; if (outstanding_o !== 3'd0) begin errors++; $display("FAIL b2b_count0: got %0d want 0", outstanding_o); end
  endtask

  task automatic test_random;
    int   m_count;
    int   m_gs;
    int   m_rs;
    logic m_wait;
    logic exp_gnt;
    logic exp_rv;
    logic [31:0] exp_rdata;
    reset_pulse();
    m_count = 0; m_gs = 0; m_rs = 0; m_wait = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!m_wait) begin
        req_i   = 1'($urandom_range(0, 1));
        addr_i  = $urandom() & 32'hffff_fffc;
        we_i    = 1'($urandom_range(0, 1));
        be_i    = 4'($urandom_range(0, 15));
        wdata_i = $urandom();
      end
      rand_gnt_i    = ($urandom_range(0, 2) == 0);
      rand_rvalid_i = ($urandom_range(0, 2) == 0);
      rand_rdata_i  = $urandom();
      rand_err_i    = 1'($urandom_range(0, 1));
      #1;
      exp_gnt = req_i && (m_count < 2) && (rand_gnt_i || (m_gs == 3));
      exp_rv  = (m_count != 0) && (rand_rvalid_i || (m_rs == 3));
      checks++; if (gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt cyc %0d: got %b want %b", cyc, gnt_o, exp_gnt); end
      checks++; if (rvalid_o !== exp_rv) begin errors++; $display("FAIL rnd_rvalid cyc %0d: got %b want %b", cyc, rvalid_o, exp_rv); end
      checks++; if (outstanding_o !== 3'(m_count)) begin errors++; $display("FAIL rnd_count cyc %0d: got %0d want %0d", cyc, outstanding_o, m_count); end
      checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL rnd_perr cyc %0d: got %b want 0", cyc, protocol_err_o); end
      if (exp_rv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_queue_empty cyc %0d: got rvalid with no expected entry", cyc);
        end else begin
          exp_e = exp_q.pop_front();
          exp_rdata = exp_e[32] ? 32'h0 : rand_rdata_i;
          checks++; if ({resp_we_o, resp_addr_o} !== exp_e) begin errors++; $display("FAIL rnd_head cyc %0d: got %b/%h want %b/%h", cyc, resp_we_o, resp_addr_o, exp_e[32], exp_e[31:0]); end
          checks++; if (rdata_o !== exp_rdata) begin errors++; $display("FAIL rnd_rdata cyc %0d: got %h want %h", cyc, rdata_o, exp_rdata); end
          checks++; if (err_o !== rand_err_i) begin errors++; $display("FAIL rnd_err cyc %0d: got %b want %b", cyc, err_o, rand_err_i); end
        end
      end else begin
        checks++; if ({rdata_o, err_o, resp_addr_o, resp_we_o} !== '0) begin
          errors++; $display("FAIL rnd_idle_resp cyc %0d: rdata %h err %b addr %h we %b want all 0", cyc, rdata_o, err_o, resp_addr_o, resp_we_o);
        end
      end
      if (exp_gnt) exp_q.push_back({we_i, addr_i});
      m_rs    = (exp_rv || (m_count == 0)) ? 0 : ((m_rs < 3) ? m_rs + 1 : m_rs);
      m_gs    = (exp_gnt || !req_i) ? 0 : ((m_gs < 3) ? m_gs + 1 : m_gs);
      m_count = m_count + int'(exp_gnt) - int'(exp_rv);
      m_wait  = req_i && !exp_gnt;
      tick();
    end
  endtask

  task automatic test_reset_mid;
    reset_pulse();
    req_i = 1'b1; addr_i = 32'h60; rand_gnt_i = 1'b1;
    #1;
    checks++; if (gnt_o !== 1'b1) begin errors++; $display("FAIL mid_gnt0: got %b want 1", gnt_o); end
    tick();
    addr_i = 32'h64;
    tick();
    reset = 1'b1;
    idle_inputs();
    rand_rvalid_i = 1'b1;
    #1;
    checks++; if ({outstanding_o, rvalid_o} !== 4'd0) begin errors++; $display("FAIL mid_async: count %0d rvalid %b want 0 0", outstanding_o, rvalid_o); end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({outstanding_o, rvalid_o} !== 4'd0) begin errors++; $display("FAIL mid_after%0d: count %0d rvalid %b want 0 0", i, outstanding_o, rvalid_o); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_protocol;
    idle_inputs();
    #1;
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL prot_clean: got %b want 0", protocol_err_o); end
    req_i = 1'b1; addr_i = 32'h20;
    #1;
    checks++; if ({gnt_o, protocol_err_o} !== 2'b00) begin errors++; $display("FAIL prot_stall: gnt %b perr %b want 0 0", gnt_o, protocol_err_o); end
    tick();
    addr_i = 32'h24;
    #1;
    checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL prot_set: got %b want 1", protocol_err_o); end
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (protocol_err_o !== 1'b1) begin errors++; $display("FAIL prot_sticky%0d: got %b want 1", i, protocol_err_o); end
      tick();
    end
    reset = 1'b1;
    #1;
    checks++; if (protocol_err_o !== 1'b0) begin errors++; $display("FAIL prot_cleared: got %b want 0", protocol_err_o); end
    tick();
    reset = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_in_order_full();
    test_fairness();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_protocol();
    checks++; if (exp_q.size() > 2) begin errors++; $display("FAIL queue_size: got %0d want at most 2", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
